// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

   // FSM state encoding shared by the divider and anything that observes it.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_FIXUP  = 2'd2
   } state_e;

   // Widest legal operand. The iteration counter is sized for this so that
   // every legal WIDTH instance can share the package.
   localparam int unsigned MAX_WIDTH = 64;
   localparam int unsigned CNT_W     = $clog2(MAX_WIDTH + 1);

   // Magnitude of a sign-extended two's-complement value. The most-negative
   // input of a narrower operand still yields the correct unsigned magnitude
   // in its low bits.
   function automatic logic [63:0] abs_val(input logic [63:0] v);
      return v[63] ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {p, a} with divisor b.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   p,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   p_next,
   output logic [WIDTH-1:0] a_next
);

   logic [WIDTH:0]   p_sh;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH+1:0] trial;

   // Shift, trial-subtract, and keep or restore the partial remainder.
   always_comb begin
      p_sh  = {p[WIDTH-1:0], a[WIDTH-1]};
      a_sh  = {a[WIDTH-2:0], 1'b0};
      // One extra bit so the sign of the trial is unambiguous.
      trial = {1'b0, p_sh} - {2'b00, b};
      if (trial[WIDTH+1]) begin
         p_next = p_sh;
         a_next = a_sh;
      end else begin
         p_next = trial[WIDTH:0];
         a_next = {a_sh[WIDTH-1:1], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done
// handshake, result packed as {quotient, remainder}.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic [2*WIDTH-1:0]   z
);

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     p;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               q_neg;
   logic               r_neg;
   logic               zero_div;

   logic               sgn;
   logic [WIDTH-1:0]   dvd_mag;
   logic [WIDTH-1:0]   dvs_mag;
   logic [WIDTH:0]     step_p;
   logic [WIDTH-1:0]   step_a;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;

   // Operand magnitudes at acceptance and sign restoration at fixup.
   always_comb begin
      sgn     = SIGNED_EN && is_signed;
      dvd_mag = sgn ? WIDTH'(abs_val(64'($signed(dividend)))) : dividend;
      dvs_mag = sgn ? WIDTH'(abs_val(64'($signed(divisor))))  : divisor;
      q_fix   = q_neg ? (~a + 1'b1) : a;
      r_fix   = r_neg ? (~p[WIDTH-1:0] + 1'b1) : p[WIDTH-1:0];
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .p      (p),
      .a      (a),
      .b      (b),
      .p_next (step_p),
      .a_next (step_a)
   );

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= S_IDLE;
         cnt         <= '0;
         p           <= '0;
         a           <= '0;
         b           <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         zero_div    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         z           <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  q_neg       <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg       <= sgn & dividend[WIDTH-1];
                  p           <= '0;
                  cnt         <= '0;
                  b           <= dvs_mag;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     // Raw dividend is passed through untouched as the remainder.
                     zero_div <= 1'b1;
                     a        <= dividend;
                     state    <= S_FIXUP;
                  end else begin
                     zero_div <= 1'b0;
                     a        <= dvd_mag;
                     state    <= S_DIVIDE;
                  end
               end
            end
            S_DIVIDE: begin
               p   <= step_p;
               a   <= step_a;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               if (zero_div) begin
                  z           <= {{WIDTH{1'b1}}, a};
                  div_by_zero <= 1'b1;
               end else begin
                  z <= {q_fix, r_fix};
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [63:0] z;

   logic        start8 = 1'b0;
   logic [7:0]  dividend8 = '0;
   logic [7:0]  divisor8 = '0;
   logic        busy8;
   logic        done8;
   logic        dz8;
   logic [15:0] z8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .z           (z)
   );

   seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
      .clk         (clk),
      .clr         (clr),
      .start       (start8),
      .is_signed   (1'b0),
      .dividend    (dividend8),
      .divisor     (divisor8),
      .busy        (busy8),
      .done        (done8),
      .div_by_zero (dz8),
      .z           (z8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, truncating division.
   function automatic logic [63:0] model(input logic sg, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {q[31:0], r[31:0]};
      end
      return {a / b, a % b};
   endfunction

   // Present an operation and step past the accepting edge.
   task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      // Later input changes must not disturb the operation.
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = ~sg;
   endtask

   // Wait (bounded) for done; optionally pulse a stray start after `inject` cycles.
   task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_z,
                            input logic exp_dz, input int inject);
      int lat = 0;
      int busy_cycles = 0;
      while (!done && lat < 200) begin
         if (busy) busy_cycles++;
         if (lat == inject) begin
            is_signed = 1'b0;
            dividend  = 32'd9;
            divisor   = 32'd3;
            start     = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
      end
      check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/busy_cycles"}, 64'(busy_cycles), 64'(exp_lat));
      check({tag, "/z"}, z, exp_z);
      check({tag, "/dz"}, 64'(div_by_zero), 64'(exp_dz));
      check({tag, "/busy_at_done"}, 64'(busy), 64'(0));
   endtask

   task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b);
      launch(sg, a, b);
      wait_done(tag, (b == 32'd0) ? 1 : 33, model(sg, a, b), b == 32'd0, -1);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          ndone;
      int          lat8;

      #12;
      check("reset/busy", 64'(busy), 64'(0));
      check("reset/done", 64'(done), 64'(0));
      check("reset/dz", 64'(div_by_zero), 64'(0));
      check("reset/z", z, 64'(0));
      clr = 1'b0;
      @(posedge clk);
      #1;

      // Directed cases; literal expectations cross-check the model.
      check("model/7_2", model(1'b0, 32'd7, 32'd2), 64'h00000003_00000001);
      run_op("u7_2", 1'b0, 32'd7, 32'd2);
      check("u7_2/lit", z, 64'h00000003_00000001);
      run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      check("s-7_2/lit", z, 64'hFFFFFFFD_FFFFFFFF);
      run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
      check("s7_-2/lit", z, 64'hFFFFFFFD_00000001);
      run_op("uF9_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
      check("uF9_2/lit", z, 64'h7FFFFFFC_00000001);
      run_op("dz100", 1'b0, 32'd100, 32'd0);
      check("dz100/lit", z, 64'hFFFFFFFF_00000064);
      @(posedge clk);
      #1;
      check("dz/held", 64'(div_by_zero), 64'(1));
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      check("dz/cleared_on_start", 64'(div_by_zero), 64'(0));
      wait_done("sovf", 33, 64'h80000000_00000000, 1'b0, -1);

      // Stray start mid-operation is ignored.
      launch(1'b0, 32'd100, 32'd7);
      wait_done("ignore_start", 33, 64'h0000000E_00000002, 1'b0, 5);

      // Start in the done cycle is accepted; z holds the old result meanwhile.
      launch(1'b0, 32'd50, 32'd6);
      wait_done("b2b_first", 33, 64'h00000008_00000002, 1'b0, -1);
      launch(1'b1, 32'hFFFF_FF9C, 32'd7);
      check("b2b/accepted_busy", 64'(busy), 64'(1));
      check("b2b/z_held", z, 64'h00000008_00000002);
      wait_done("b2b_second", 33, model(1'b1, 32'hFFFF_FF9C, 32'd7), 1'b0, -1);

      // Asynchronous clear mid-operation abandons it.
      launch(1'b0, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      clr = 1'b1;
      #1;
      check("clr/busy", 64'(busy), 64'(0));
      check("clr/done", 64'(done), 64'(0));
      check("clr/z", z, 64'(0));
      check("clr/dz", 64'(div_by_zero), 64'(0));
      #2;
      clr = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("clr/no_done", 64'(ndone), 64'(0));
      run_op("after_clr", 1'b0, 32'd1000, 32'd3);

      // Randomized operations, with a bias toward interesting divisors.
      for (int i = 0; i < 24; i++) begin
         rs = 1'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'h8000_0000;
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), rs, ra, rb);
      end

      // Narrow instance: 200 / 9 = 22 rem 2 after 9 edges.
      dividend8 = 8'd200;
      divisor8  = 8'd9;
      start8    = 1'b1;
      @(posedge clk);
      #1;
      start8    = 1'b0;
      dividend8 = 8'd1;
      divisor8  = 8'd1;
      lat8 = 0;
      while (!done8 && lat8 < 100) begin
         @(posedge clk);
         #1;
         lat8++;
      end
      check("w8/latency", 64'(lat8), 64'(9));
      check("w8/z", 64'(z8), 64'({8'd22, 8'd2}));
      check("w8/dz", 64'(dz8), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
